// File: rtl/nes_pad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_pkg
// Purpose  : Shared types and constants for the NES controller port emulation.
//            Provides the shifter state encoding, the button bit positions
//            within the button byte, and the button byte width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nes_pad_pkg;

  localparam int NES_PAD_BITS = 8;

  // Bit positions inside the button byte (1 = pressed)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    LATCH   = 2'd0,
    SHIFT   = 2'd1,
    EXHAUST = 2'd2
  } pad_state_t;

endpackage
`default_nettype wire

// File: rtl/nes_pad_turbo.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_turbo
// Purpose  : Turbo gating for the A and B buttons. A phase flop toggles once
//            every TURBO_POLLS strobe falling edges; while the phase is high,
//            turbo-enabled A/B buttons read as released. Only instantiated
//            when NES_PAD_TURBO_EN is defined.
// Ports    : clk          - system clock
//            reset        - asynchronous active-high reset
//            i_poll       - one-cycle pulse on a strobe 1->0 transition
//            i_buttons    - live button byte
//            i_turbo_en   - [0] turbo A, [1] turbo B
//            o_btn_eff    - gated button byte
// Revision : 1.0 - initial release
// ============================================================================
module nes_pad_turbo
  import nes_pad_pkg::*;
#(
  parameter int TURBO_POLLS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_poll,
  input  logic [NES_PAD_BITS-1:0] i_buttons,
  input  logic [1:0]              i_turbo_en,
  output logic [NES_PAD_BITS-1:0] o_btn_eff
);

  localparam int CNT_W = (TURBO_POLLS > 1) ? $clog2(TURBO_POLLS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURBO_POLLS - 1);

  logic [CNT_W-1:0] r_poll_cnt;
  logic             r_turbo_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_poll_cnt    <= '0;
      r_turbo_phase <= 1'b0;
    end else if (i_poll) begin
      if (r_poll_cnt == CNT_LAST) begin
        r_poll_cnt    <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_poll_cnt <= r_poll_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_btn_eff         = i_buttons;
    o_btn_eff[BTN_A]  = i_buttons[BTN_A] & ~(i_turbo_en[0] & r_turbo_phase);
    o_btn_eff[BTN_B]  = i_buttons[BTN_B] & ~(i_turbo_en[1] & r_turbo_phase);
  end

endmodule
`default_nettype wire

// File: rtl/nes_pad_shifter.sv
`default_nettype none
// ============================================================================
// Module   : nes_pad_shifter
// Purpose  : One NES controller port (CD4021-style latch + serial shifter).
//            Takes the live button byte from the PIO and serves it bit-serially
//            to CPU reads of $4016/$4017 after a strobe 1->0 sequence.
//            Optional feature macro: NES_PAD_TURBO_EN (adds i_turbo_en port,
//            TURBO_POLLS parameter and the nes_pad_turbo gating sub-module).
// Ports    : clk            - system clock, all logic on posedge
//            reset          - asynchronous active-high reset
//            i_buttons_in   - button byte, 1=pressed, [0]A..[7]Right
//            i_strobe_we    - one-cycle pulse, CPU write to $4016
//            i_strobe_wdata - bit 0 of that write
//            i_cpu_rd       - one-cycle pulse, CPU read of this port
//            o_cpu_data     - serial bit presented to the CPU, 1=pressed
//            o_poll_count   - strobe falling-edge count, wraps at 255
//            i_turbo_en     - turbo enables [0]A [1]B (macro builds only)
// Revision : 1.0 - initial release
// ============================================================================
module nes_pad_shifter
  import nes_pad_pkg::*;
`ifdef NES_PAD_TURBO_EN
#(
  parameter int TURBO_POLLS = 2
)
`endif
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NES_PAD_BITS-1:0] i_buttons_in,
  input  logic                    i_strobe_we,
  input  logic                    i_strobe_wdata,
  input  logic                    i_cpu_rd,
  output logic                    o_cpu_data,
  output logic [7:0]              o_poll_count
`ifdef NES_PAD_TURBO_EN
  ,
  input  logic [1:0]              i_turbo_en
`endif
);

  pad_state_t              r_state, w_state;
  logic                    r_strobe_q;
  logic [NES_PAD_BITS-1:0] r_shift_q, w_shift;
  logic [3:0]              r_bit_cnt, w_bit_cnt;
  logic [7:0]              r_poll_count, w_poll;
  logic [NES_PAD_BITS-1:0] w_btn_eff;
  logic                    w_rise;
  logic                    w_fall;

  // Strobe edges are judged against the registered strobe, so repeated
  // writes of the same value produce no transition.
  assign w_rise = i_strobe_we &  i_strobe_wdata & ~r_strobe_q;
  assign w_fall = i_strobe_we & ~i_strobe_wdata &  r_strobe_q;

`ifdef NES_PAD_TURBO_EN
  nes_pad_turbo #(
    .TURBO_POLLS (TURBO_POLLS)
  ) u_turbo (
    .clk        (clk),
    .reset      (reset),
    .i_poll     (w_fall),
    .i_buttons  (i_buttons_in),
    .i_turbo_en (i_turbo_en),
    .o_btn_eff  (w_btn_eff)
  );
`else
  assign w_btn_eff = i_buttons_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe_q   <= 1'b0;
      r_shift_q    <= '0;
      r_bit_cnt    <= '0;
      r_state      <= EXHAUST;
      r_poll_count <= '0;
    end else begin
      if (i_strobe_we) begin
        r_strobe_q <= i_strobe_wdata;
      end
      r_shift_q    <= w_shift;
      r_bit_cnt    <= w_bit_cnt;
      r_state      <= w_state;
      r_poll_count <= w_poll;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift_q;
    w_bit_cnt = r_bit_cnt;
    w_poll    = r_poll_count;

    if (w_rise) begin
      // A strobe write of 1 overrides any read in the same cycle.
      w_state   = LATCH;
      w_shift   = w_btn_eff;
      w_bit_cnt = '0;
    end else if (r_strobe_q) begin
      // Transparent while strobe is high; the falling-edge cycle also loads,
      // so the shifter captures the buttons seen alongside the 0-write.
      w_shift   = w_btn_eff;
      w_bit_cnt = '0;
      if (w_fall) begin
        w_state = SHIFT;
        w_poll  = r_poll_count + 8'd1;
      end else begin
        w_state = LATCH;
      end
    end else if ((r_state == SHIFT) && i_cpu_rd) begin
      // Ones fill from the top so reads past the eighth return 1.
      w_shift   = {1'b1, r_shift_q[NES_PAD_BITS-1:1]};
      w_bit_cnt = r_bit_cnt + 4'd1;
      if (r_bit_cnt == 4'd7) begin
        w_state = EXHAUST;
      end
    end
  end

  always_comb begin
    o_cpu_data = 1'b1;
    case (r_state)
      LATCH:   o_cpu_data = w_btn_eff[BTN_A];
      SHIFT:   o_cpu_data = r_shift_q[0];
      default: o_cpu_data = 1'b1;
    endcase
  end

  assign o_poll_count = r_poll_count;

endmodule
`default_nettype wire
